// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry add two WIDTH-bit
// operands plus carry-in, LSB first, one bit per clock.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    count;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             bit_s;
  logic             carry_next;
  logic             last_bit;

  // Handshake: start is a request sampled only in IDLE; anything else is dropped.
  // done is a one-cycle pulse and sum/cout/ovf are already final while it is high.
  assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (carry & a_sr[0]);
  assign last_bit   = (count == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      count  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        SHIFT: begin
          // Result fills from the MSB end so bit i lands in sum[i] after WIDTH shifts.
          sum_r <= {bit_s, sum_r[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_next;
          count <= count + CW'(1);
          if (last_bit) begin
            cout_r <= carry_next;
            // carry here is the carry into the MSB; overflow is it XOR the carry out.
            ovf_r  <= carry ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed cases, handshake
// corner cases, async abort and a random sweep checked against a+b+cin.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int vectors = 0;
  int errors  = 0;

  // {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0]   full;
    logic         v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  // Drives operands and raises start; pushes the expectation to the scoreboard.
  task automatic apply_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    exp_q.push_back(model(x, y, c));
  endtask

  // Advances clocks until done is seen (or the budget expires), dropping start after the first edge.
  task automatic collect(output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) break;
      if (lat > 40) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sum, cout, ovf, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum, cout, ovf, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int           lat;
    bit           to;
    logic [W+1:0] e;
    apply_op(8'h5A, 8'h3C, 1'b0);
    collect(lat, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || lat != W + 1) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d (timeout=%0b)", lat, W + 1, to);
    end
    vectors++;
    if ({cout, ovf, sum} !== e || e !== 10'h196) begin
      errors++;
      $display("FAIL basic_result got %h want %h", {cout, ovf, sum}, e);
    end
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_in_done got %b want 1", busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cout, ovf, sum} !== e) begin
      errors++;
      $display("FAIL basic_hold got %h want %h", {cout, ovf, sum}, e);
    end
  endtask

  task automatic test_carry_and_overflow;
    logic [W-1:0] ta[4] = '{8'hFF, 8'hFF, 8'h80, 8'h7F};
    logic [W-1:0] tb[4] = '{8'h01, 8'h00, 8'h80, 8'h01};
    logic         tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] want[4] = '{10'h200, 10'h200, 10'h300, 10'h180};
    int           lat;
    bit           to;
    logic [W+1:0] e;
    for (int i = 0; i < 4; i++) begin
      apply_op(ta[i], tb[i], tc[i]);
      collect(lat, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || {cout, ovf, sum} !== e || e !== want[i]) begin
        errors++;
        $display("FAIL edge_case_%0d got %h want %h (timeout=%0b)", i, {cout, ovf, sum},
                 want[i], to);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignored_start;
    int           dones;
    logic [W+1:0] e;
    dones = 0;
    apply_op(8'h10, 8'h20, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
      if (done) begin
        dones++;
        e = exp_q.pop_front();
        vectors++;
        if ({cout, ovf, sum} !== e || sum !== 8'h30) begin
          errors++;
          $display("FAIL ignored_start_result got %h want %h", {cout, ovf, sum}, e);
        end
      end
    end
    vectors++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_pulses got %0d busy=%b want 1 busy=0", dones, busy);
    end
  endtask

  task automatic test_back_to_back;
    int           first_done;
    int           gap;
    int           idle_cycles;
    int           seen;
    logic [W+1:0] e;
    first_done  = -1;
    gap         = -1;
    idle_cycles = 0;
    seen        = 0;
    apply_op(8'h12, 8'h34, 1'b1);
    exp_q.push_back(model(8'hC3, 8'h5A, 1'b0));
    for (int cyc = 1; cyc <= 30 && seen < 2; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        a   = 8'hC3;
        b   = 8'h5A;
        cin = 1'b0;
      end
      if (first_done >= 0 && seen == 1 && !busy) idle_cycles++;
      if (done) begin
        seen++;
        e = exp_q.pop_front();
        vectors++;
        if ({cout, ovf, sum} !== e) begin
          errors++;
          $display("FAIL back_to_back_result_%0d got %h want %h", seen, {cout, ovf, sum}, e);
        end
        if (seen == 1) first_done = cyc;
        else begin
          gap   = cyc - first_done;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (gap != W + 2 || idle_cycles != 1) begin
      errors++;
      $display("FAIL back_to_back_spacing got gap=%0d idle=%0d want gap=%0d idle=1",
               gap, idle_cycles, W + 2);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    int           dones;
    int           lat;
    bit           to;
    logic [W+1:0] e;
    dones = 0;
    apply_op(8'hFF, 8'h00, 1'b0);
    void'(exp_q.pop_back());
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (done) dones++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sum, cout, ovf, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_async got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum, cout, ovf, busy, done);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2) rst_n = 1'b1;
      if (done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", dones);
    end
    apply_op(8'h01, 8'h01, 1'b0);
    collect(lat, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || {cout, ovf, sum} !== e || sum !== 8'h02) begin
      errors++;
      $display("FAIL abort_recover got %h want %h (timeout=%0b)", {cout, ovf, sum}, e, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int           lat;
    bit           to;
    logic [W+1:0] e;
    for (int i = 0; i < 1000; i++) begin
      apply_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
      collect(lat, to);
      e = exp_q.pop_front();
      vectors++;
      if (to || lat != W + 1 || {cout, ovf, sum} !== e) begin
        errors++;
        $display("FAIL random_%0d got %h lat=%0d want %h lat=%0d", i, {cout, ovf, sum}, lat,
                 e, W + 1);
      end
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_and_overflow();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
